// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_stage
// Purpose  : ID/EX pipeline register with load-use hazard detection, bubble
//            insertion on stall or flush, and a saturating stall counter.
// Revision : 1.0 - initial release
// ============================================================================
module id_ex_stage #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               idValid,
  input  logic               RegDst,
  input  logic               Branch,
  input  logic               MemRead,
  input  logic               MemToReg,
  input  logic               MemWrite,
  input  logic               ALUSrc,
  input  logic               RegWrite,
  input  logic               Jump,
  input  logic [1:0]         ALUOp,
  input  logic [DATA_W-1:0]  idPcPlus4,
  input  logic [DATA_W-1:0]  idReadData1,
  input  logic [DATA_W-1:0]  idReadData2,
  input  logic [DATA_W-1:0]  idSignExtImm,
  input  logic [RADDR_W-1:0] idRs,
  input  logic [RADDR_W-1:0] idRt,
  input  logic [RADDR_W-1:0] idRd,
  output logic               exRegDst,
  output logic               exBranch,
  output logic               exMemRead,
  output logic               exMemToReg,
  output logic               exMemWrite,
  output logic               exALUSrc,
  output logic               exRegWrite,
  output logic               exJump,
  output logic [1:0]         exALUOp,
  output logic [DATA_W-1:0]  exPcPlus4,
  output logic [DATA_W-1:0]  exReadData1,
  output logic [DATA_W-1:0]  exReadData2,
  output logic [DATA_W-1:0]  exSignExtImm,
  output logic [RADDR_W-1:0] exRs,
  output logic [RADDR_W-1:0] exRt,
  output logic [RADDR_W-1:0] exRd,
  output logic               exValid,
  output logic               pcWrite,
  output logic               ifIdWrite,
  output logic [CNT_W-1:0]   stallCount
);

  // Control bundle layout: {RegDst,Branch,MemRead,MemToReg,MemWrite,ALUSrc,RegWrite,Jump,ALUOp[1:0]}
  localparam int CTRL_W      = 10;
  localparam int C_MEMREAD_B = 7;

  logic [CTRL_W-1:0]  ctrl_in;
  logic [CTRL_W-1:0]  ctrl_d, ctrl_q;
  logic               valid_d, valid_q;
  logic [CNT_W-1:0]   cnt_d, cnt_q;
  logic [DATA_W-1:0]  pc_q, rd1_q, rd2_q, imm_q;
  logic [RADDR_W-1:0] rs_q, rt_q, rd_q;
  logic               hazard, stall, bubble;

  assign ctrl_in = {RegDst, Branch, MemRead, MemToReg, MemWrite,
                    ALUSrc, RegWrite, Jump, ALUOp};

  // Load in EX writing a nonzero rt that the ID instruction reads.
  assign hazard = valid_q & ctrl_q[C_MEMREAD_B] & (rt_q != '0) & idValid &
                  ((rt_q == idRs) | (rt_q == idRt));
  assign stall     = hazard & ~flush;
  assign bubble    = flush | stall;
  assign pcWrite   = ~stall;
  assign ifIdWrite = ~stall;

  // Next-state: bubble forces known-zero controls; otherwise pass decoder controls through.
  always_comb begin
    ctrl_d  = '0;
    valid_d = 1'b0;
    cnt_d   = cnt_q;
    if (!bubble && idValid) begin
      ctrl_d  = ctrl_in;
      valid_d = 1'b1;
    end
    if (stall && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Pipeline register; data fields are captured every cycle (don't-care under a bubble).
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q  <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      pc_q    <= '0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      imm_q   <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      rd_q    <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      pc_q    <= idPcPlus4;
      rd1_q   <= idReadData1;
      rd2_q   <= idReadData2;
      imm_q   <= idSignExtImm;
      rs_q    <= idRs;
      rt_q    <= idRt;
      rd_q    <= idRd;
    end
  end

  assign {exRegDst, exBranch, exMemRead, exMemToReg, exMemWrite,
          exALUSrc, exRegWrite, exJump, exALUOp} = ctrl_q;
  assign exValid      = valid_q;
  assign stallCount   = cnt_q;
  assign exPcPlus4    = pc_q;
  assign exReadData1  = rd1_q;
  assign exReadData2  = rd2_q;
  assign exSignExtImm = imm_q;
  assign exRs         = rs_q;
  assign exRt         = rt_q;
  assign exRd         = rd_q;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_ex_stage
// Purpose  : Self-checking bench for id_ex_stage (directed scenarios plus
//            randomized traffic against a behavioural pipeline model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 4;
  localparam logic [CW-1:0] CNT_MAX = '1;

  // Control vector layout used by the bench:
  // {RegDst,Branch,MemRead,MemToReg,MemWrite,ALUSrc,RegWrite,Jump,ALUOp}
  localparam logic [9:0] C_LW  = 10'b0011011000;
  localparam logic [9:0] C_ADD = 10'b1000001010;

  logic clk = 1'b0;
  logic reset, flush, idValid;
  logic RegDst, Branch, MemRead, MemToReg, MemWrite, ALUSrc, RegWrite, Jump;
  logic [1:0] ALUOp;
  logic [DW-1:0] idPcPlus4, idReadData1, idReadData2, idSignExtImm;
  logic [AW-1:0] idRs, idRt, idRd;
  logic exRegDst, exBranch, exMemRead, exMemToReg, exMemWrite, exALUSrc, exRegWrite, exJump;
  logic [1:0] exALUOp;
  logic [DW-1:0] exPcPlus4, exReadData1, exReadData2, exSignExtImm;
  logic [AW-1:0] exRs, exRt, exRd;
  logic exValid, pcWrite, ifIdWrite;
  logic [CW-1:0] stallCount;
  logic [9:0] ex_ctrl;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(DW), .RADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .flush(flush), .idValid(idValid),
    .RegDst(RegDst), .Branch(Branch), .MemRead(MemRead), .MemToReg(MemToReg),
    .MemWrite(MemWrite), .ALUSrc(ALUSrc), .RegWrite(RegWrite), .Jump(Jump),
    .ALUOp(ALUOp), .idPcPlus4(idPcPlus4), .idReadData1(idReadData1),
    .idReadData2(idReadData2), .idSignExtImm(idSignExtImm),
    .idRs(idRs), .idRt(idRt), .idRd(idRd),
    .exRegDst(exRegDst), .exBranch(exBranch), .exMemRead(exMemRead),
    .exMemToReg(exMemToReg), .exMemWrite(exMemWrite), .exALUSrc(exALUSrc),
    .exRegWrite(exRegWrite), .exJump(exJump), .exALUOp(exALUOp),
    .exPcPlus4(exPcPlus4), .exReadData1(exReadData1), .exReadData2(exReadData2),
    .exSignExtImm(exSignExtImm), .exRs(exRs), .exRt(exRt), .exRd(exRd),
    .exValid(exValid), .pcWrite(pcWrite), .ifIdWrite(ifIdWrite),
    .stallCount(stallCount)
  );

  assign ex_ctrl = {exRegDst, exBranch, exMemRead, exMemToReg, exMemWrite,
                    exALUSrc, exRegWrite, exJump, exALUOp};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [9:0] c,
                        input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                        input logic [AW-1:0] rd, input logic [DW-1:0] d1,
                        input logic [DW-1:0] d2, input logic [DW-1:0] imm,
                        input logic [DW-1:0] pc);
    idValid = v;
    {RegDst, Branch, MemRead, MemToReg, MemWrite, ALUSrc, RegWrite, Jump, ALUOp} = c;
    idRs = rs; idRt = rt; idRd = rd;
    idReadData1 = d1; idReadData2 = d2; idSignExtImm = imm; idPcPlus4 = pc;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0;
    set_id(1'b1, 10'h3FF, 5'd1, 5'd2, 5'd3, 32'hAAAA, 32'hBBBB, 32'hCCCC, 32'h40);
    tick();
    tick();
    total++; if (exValid !== 1'b0) begin bad++; $display("FAIL reset_exValid got=%b exp=0", exValid); end
    total++; if (ex_ctrl !== 10'd0) begin bad++; $display("FAIL reset_ctrl got=%b exp=0", ex_ctrl); end
    total++; if ({exPcPlus4, exReadData1, exReadData2, exSignExtImm} !== 128'd0 ||
                 {exRs, exRt, exRd} !== 15'd0) begin
      bad++; $display("FAIL reset_data got=%h/%h/%h exp=0", exReadData1, exReadData2, exRd);
    end
    total++; if (stallCount !== '0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", stallCount); end
    total++; if (pcWrite !== 1'b1 || ifIdWrite !== 1'b1) begin
      bad++; $display("FAIL reset_pcWrite got=%b/%b exp=1/1", pcWrite, ifIdWrite);
    end
    reset = 1'b0;
  endtask

  task automatic test_rtype();
    set_id(1'b1, C_ADD, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'h0000_1820, 32'h104);
    tick();
    total++; if (exRegDst !== 1'b1 || exALUOp !== 2'b10 || exRegWrite !== 1'b1) begin
      bad++; $display("FAIL rtype_ctrl got=%b exp=%b", ex_ctrl, C_ADD);
    end
    total++; if (exReadData1 !== 32'd5 || exReadData2 !== 32'd7 || exRd !== 5'd3 ||
                 exPcPlus4 !== 32'h104 || exSignExtImm !== 32'h1820) begin
      bad++; $display("FAIL rtype_data got=%0d,%0d,rd%0d exp=5,7,rd3", exReadData1, exReadData2, exRd);
    end
    total++; if (exValid !== 1'b1) begin bad++; $display("FAIL rtype_valid got=%b exp=1", exValid); end
  endtask

  task automatic test_load_use();
    set_id(1'b1, C_LW, 5'd1, 5'd2, 5'd0, 32'd100, 32'd0, 32'd0, 32'h200);
    tick();
    set_id(1'b1, C_ADD, 5'd2, 5'd3, 5'd4, 32'd9, 32'd8, 32'd0, 32'h204);
    #1;
    total++; if (pcWrite !== 1'b0 || ifIdWrite !== 1'b0) begin
      bad++; $display("FAIL lu_stall got=%b/%b exp=0/0", pcWrite, ifIdWrite);
    end
    tick();
    total++; if (exValid !== 1'b0 || exRegWrite !== 1'b0 || exMemRead !== 1'b0) begin
      bad++; $display("FAIL lu_bubble got v=%b ctrl=%b exp v=0 ctrl=0", exValid, ex_ctrl);
    end
    total++; if (stallCount !== 4'd1) begin bad++; $display("FAIL lu_cnt got=%0d exp=1", stallCount); end
    total++; if (pcWrite !== 1'b1) begin bad++; $display("FAIL lu_release got=%b exp=1", pcWrite); end
    tick();
    total++; if (exValid !== 1'b1 || ex_ctrl !== C_ADD || exRd !== 5'd4 || exReadData1 !== 32'd9) begin
      bad++; $display("FAIL lu_add got v=%b ctrl=%b rd=%0d exp v=1 ctrl=%b rd=4", exValid, ex_ctrl, exRd, C_ADD);
    end
    total++; if (stallCount !== 4'd1) begin bad++; $display("FAIL lu_cnt2 got=%0d exp=1", stallCount); end
  endtask

  task automatic test_zero_reg();
    set_id(1'b1, C_LW, 5'd1, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'h300);
    tick();
    set_id(1'b1, C_ADD, 5'd0, 5'd3, 5'd4, 32'd0, 32'd1, 32'd0, 32'h304);
    #1;
    total++; if (pcWrite !== 1'b1) begin bad++; $display("FAIL zero_nostall got=%b exp=1", pcWrite); end
    tick();
    total++; if (exValid !== 1'b1 || exRd !== 5'd4 || stallCount !== 4'd1) begin
      bad++; $display("FAIL zero_pass got v=%b rd=%0d cnt=%0d exp v=1 rd=4 cnt=1", exValid, exRd, stallCount);
    end
  endtask

  task automatic test_flush();
    set_id(1'b1, C_LW, 5'd1, 5'd2, 5'd0, 32'd0, 32'd0, 32'd0, 32'h400);
    tick();
    set_id(1'b1, C_ADD, 5'd3, 5'd2, 5'd4, 32'd0, 32'd0, 32'd0, 32'h404);
    flush = 1'b1;
    #1;
    total++; if (pcWrite !== 1'b1 || ifIdWrite !== 1'b1) begin
      bad++; $display("FAIL flush_pw got=%b/%b exp=1/1", pcWrite, ifIdWrite);
    end
    tick();
    flush = 1'b0;
    total++; if (exValid !== 1'b0 || ex_ctrl !== 10'd0 || stallCount !== 4'd1) begin
      bad++; $display("FAIL flush_bubble got v=%b ctrl=%b cnt=%0d exp v=0 ctrl=0 cnt=1", exValid, ex_ctrl, stallCount);
    end
  endtask

  task automatic test_saturation();
    int exp_cnt;
    exp_cnt = 1;
    for (int k = 0; k < 20; k++) begin
      set_id(1'b1, C_LW, 5'd1, 5'd5, 5'd0, 32'd0, 32'd0, 32'd0, 32'h500);
      tick();
      set_id(1'b1, C_ADD, 5'd5, 5'd6, 5'd7, 32'd0, 32'd0, 32'd0, 32'h504);
      tick();
      tick();
      if (exp_cnt < 15) exp_cnt++;
      total++; if (stallCount !== exp_cnt[CW-1:0]) begin
        bad++; $display("FAIL sat_cnt pair=%0d got=%0d exp=%0d", k, stallCount, exp_cnt);
      end
    end
  endtask

  task automatic test_reset_mid_stall();
    set_id(1'b1, C_LW, 5'd1, 5'd2, 5'd0, 32'd0, 32'd0, 32'd0, 32'h600);
    tick();
    set_id(1'b1, C_ADD, 5'd2, 5'd3, 5'd4, 32'd0, 32'd0, 32'd0, 32'h604);
    #1;
    total++; if (pcWrite !== 1'b0) begin bad++; $display("FAIL rms_stall got=%b exp=0", pcWrite); end
    reset = 1'b1;
    tick();
    total++; if (exValid !== 1'b0 || ex_ctrl !== 10'd0 || stallCount !== '0 || pcWrite !== 1'b1) begin
      bad++; $display("FAIL rms_clear got v=%b ctrl=%b cnt=%0d pw=%b exp 0/0/0/1", exValid, ex_ctrl, stallCount, pcWrite);
    end
    reset = 1'b0;
  endtask

  // Behavioural model: tracks the instruction occupying EX as a record.
  task automatic test_random();
    logic          m_valid;
    logic [9:0]    m_ctrl;
    logic          m_dknown;
    logic [127:0]  m_data;
    logic [14:0]   m_regs;
    int            m_cnt;
    logic          load_use, exp_pw;
    logic [9:0]    c;
    m_valid = 0; m_ctrl = 0; m_dknown = 1; m_data = 0; m_regs = 0; m_cnt = 0;
    reset = 1'b1; flush = 1'b0;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 400; i++) begin
      c = 10'($urandom);
      set_id($urandom_range(0, 9) < 8, c, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             5'($urandom), $urandom, $urandom, $urandom, $urandom);
      flush = ($urandom_range(0, 9) == 0);
      reset = ($urandom_range(0, 59) == 0);
      #1;
      // A valid load in EX writing a nonzero register that the ID instruction reads.
      load_use = m_valid && m_ctrl[7] && (m_regs[9:5] != 0) && idValid &&
                 (m_regs[9:5] == idRs || m_regs[9:5] == idRt);
      exp_pw = !(load_use && !flush);
      total++; if (pcWrite !== exp_pw || ifIdWrite !== exp_pw) begin
        bad++; $display("FAIL rnd_pw i=%0d got=%b/%b exp=%b", i, pcWrite, ifIdWrite, exp_pw);
      end
      if (reset) begin
        m_valid = 0; m_ctrl = 0; m_dknown = 1; m_data = 0; m_regs = 0; m_cnt = 0;
      end else begin
        if (load_use && !flush && m_cnt < 15) m_cnt = m_cnt + 1;
        if (flush || load_use) begin
          m_valid = 0; m_ctrl = 0; m_dknown = 0;
        end else begin
          m_valid  = idValid;
          m_ctrl   = idValid ? c : 10'd0;
          m_dknown = 1;
          m_data   = {idPcPlus4, idReadData1, idReadData2, idSignExtImm};
          m_regs   = {idRs, idRt, idRd};
        end
      end
      tick();
      total++; if (exValid !== m_valid || ex_ctrl !== m_ctrl) begin
        bad++; $display("FAIL rnd_ctrl i=%0d got v=%b c=%b exp v=%b c=%b", i, exValid, ex_ctrl, m_valid, m_ctrl);
      end
      total++; if (stallCount !== m_cnt[CW-1:0]) begin
        bad++; $display("FAIL rnd_cnt i=%0d got=%0d exp=%0d", i, stallCount, m_cnt);
      end
      if (m_dknown) begin
        total++;
        if ({exPcPlus4, exReadData1, exReadData2, exSignExtImm} !== m_data ||
            {exRs, exRt, exRd} !== m_regs) begin
          bad++; $display("FAIL rnd_data i=%0d got=%h exp=%h", i, {exRs, exRt, exRd}, m_regs);
        end
      end
      // Data fields are don't-care under a bubble; keep register fields
      // coherent with the DUT only for the hazard rule, which requires exValid=1.
      if (!m_dknown) m_regs = {exRs, exRt, exRd};
    end
    reset = 1'b0; flush = 1'b0;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0;
    set_id(1'b0, 10'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    test_reset();
    test_rtype();
    test_load_use();
    test_zero_reg();
    test_flush();
    test_saturation();
    test_reset_mid_stall();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  if (CNT_MAX == 0) begin : g_never
  end

endmodule
`default_nettype wire
